// File: rtl/flash_loader.sv
// Flash loader: takes a stream of program bytes and packs them into 32-bit
// little-endian words. It writes each finished word into instruction memory
// and holds the core in reset while a programming session is in progress.
module flash_loader #(
    parameter int IMEM_WORDS = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flash,
    input  logic [7:0]  data,
    input  logic [13:0] addr,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [11:0] imem_waddr,
    output logic [31:0] imem_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic [12:0] word_count,
    output logic        err
);

    localparam logic [12:0] WORDS_LIMIT = 13'(IMEM_WORDS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMMIT,
        FLUSH,
        DONE
    } state_t;

    state_t      state_q;
    logic [31:0] wordBuf_q;
    logic [3:0]  laneMask_q;
    logic [11:0] wordAddr_q;
    logic        imemWe_q;
    logic [11:0] imemWaddr_q;
    logic [31:0] imemWdata_q;
    logic        cpuHold_q;
    logic        loadDone_q;
    logic [12:0] wordCount_q;
    logic        err_q;

    logic        accept;
    logic        inRange;
    logic        wordMismatch;
    logic [12:0] countNext;
    logic [31:0] mergedWord_d;
    logic [3:0]  mergedMask_d;

    assign byte_ready   = (state_q == LOAD) && flash;
    assign accept       = byte_valid && byte_ready;
    assign inRange      = {1'b0, addr[13:2]} < WORDS_LIMIT;
    assign wordMismatch = (laneMask_q != 4'd0) && (addr[13:2] != wordAddr_q);
    assign countNext    = (wordCount_q >= WORDS_LIMIT) ? wordCount_q : wordCount_q + 13'd1;

    // Merge the incoming byte into its lane. A byte that belongs to a new word starts from an empty buffer.
    always_comb begin
        mergedWord_d = wordMismatch ? 32'd0 : wordBuf_q;
        mergedMask_d = wordMismatch ? 4'd0 : laneMask_q;
        case (addr[1:0])
            2'd0:    mergedWord_d[7:0]   = data;
            2'd1:    mergedWord_d[15:8]  = data;
            2'd2:    mergedWord_d[23:16] = data;
            default: mergedWord_d[31:24] = data;
        endcase
        mergedMask_d = mergedMask_d | (4'b0001 << addr[1:0]);
    end

    // Session FSM. The write strobe, address and data are registered when a word completes, so they appear in the COMMIT/FLUSH cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            wordBuf_q   <= '0;
            laneMask_q  <= '0;
            wordAddr_q  <= '0;
            imemWe_q    <= 1'b0;
            imemWaddr_q <= '0;
            imemWdata_q <= '0;
            cpuHold_q   <= 1'b0;
            loadDone_q  <= 1'b0;
            wordCount_q <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flash) begin
                        state_q     <= LOAD;
                        cpuHold_q   <= 1'b1;
                        wordCount_q <= '0;
                        err_q       <= 1'b0;
                        laneMask_q  <= '0;
                        wordBuf_q   <= '0;
                        wordAddr_q  <= '0;
                    end
                end
                LOAD: begin
                    if (!flash) begin
                        if (laneMask_q != 4'd0) begin
                            state_q     <= FLUSH;
                            imemWe_q    <= 1'b1;
                            imemWaddr_q <= wordAddr_q;
                            imemWdata_q <= wordBuf_q;
                            wordCount_q <= countNext;
                            laneMask_q  <= '0;
                            wordBuf_q   <= '0;
                        end else begin
                            state_q    <= DONE;
                            loadDone_q <= 1'b1;
                        end
                    end else if (accept) begin
                        if (!inRange) begin
                            err_q <= 1'b1;
                        end else begin
                            if (wordMismatch) begin
                                err_q <= 1'b1;
                            end
                            wordAddr_q <= addr[13:2];
                            if (addr[1:0] == 2'd3) begin
                                state_q     <= COMMIT;
                                imemWe_q    <= 1'b1;
                                imemWaddr_q <= addr[13:2];
                                imemWdata_q <= mergedWord_d;
                                wordCount_q <= countNext;
                                laneMask_q  <= '0;
                                wordBuf_q   <= '0;
                            end else begin
                                wordBuf_q  <= mergedWord_d;
                                laneMask_q <= mergedMask_d;
                            end
                        end
                    end
                end
                COMMIT: begin
                    imemWe_q    <= 1'b0;
                    imemWaddr_q <= '0;
                    imemWdata_q <= '0;
                    state_q     <= LOAD;
                end
                FLUSH: begin
                    imemWe_q    <= 1'b0;
                    imemWaddr_q <= '0;
                    imemWdata_q <= '0;
                    loadDone_q  <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    loadDone_q <= 1'b0;
                    cpuHold_q  <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign imem_we    = imemWe_q;
    assign imem_waddr = imemWaddr_q;
    assign imem_wdata = imemWdata_q;
    assign cpu_hold   = cpuHold_q;
    assign load_done  = loadDone_q;
    assign word_count = wordCount_q;
    assign err        = err_q;

endmodule

// File: tb/tb_flash_loader.sv
// Testbench for flash_loader. Directed byte sequences push the expected
// memory writes and session-end pulses into a scoreboard queue. A monitor
// pops an entry each time the DUT strobes imem_we or load_done.
module tb_flash_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flash = 1'b0;
    logic [7:0]  data = '0;
    logic [13:0] addr = '0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        imem_we;
    logic [11:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic [12:0] word_count;
    logic        err;

    flash_loader #(.IMEM_WORDS(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .flash      (flash),
        .data       (data),
        .addr       (addr),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .word_count (word_count),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        isDone;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [12:0] count;
    } expItem_t;

    expItem_t expQ[$];
    int testsRun = 0;
    int testsFailed = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic expectWrite(input logic [11:0] wa, input logic [31:0] wd, input logic [12:0] cnt);
        expItem_t item;
        item.isDone = 1'b0;
        item.waddr  = wa;
        item.wdata  = wd;
        item.count  = cnt;
        expQ.push_back(item);
    endtask

    task automatic expectDone(input logic [12:0] cnt);
        expItem_t item;
        item.isDone = 1'b1;
        item.waddr  = '0;
        item.wdata  = '0;
        item.count  = cnt;
        expQ.push_back(item);
    endtask

    // Present one byte (called at a falling edge) and wait until it is accepted.
    task automatic applyStimulus(input logic [13:0] a, input logic [7:0] d, input bit keep, output int waited);
        waited = 0;
        addr = a;
        data = d;
        byte_valid = 1'b1;
        while (!byte_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("byteAccepted", {31'd0, byte_ready}, 32'd1);
        @(negedge clk);
        if (!keep) byte_valid = 1'b0;
    endtask

    task automatic startSession();
        flash = 1'b1;
        @(negedge clk);
        checkOutput("startHold", {31'd0, cpu_hold}, 32'd1);
        checkOutput("startReady", {31'd0, byte_ready}, 32'd1);
        checkOutput("startErrClear", {31'd0, err}, 32'd0);
        checkOutput("startCountClear", {19'd0, word_count}, 32'd0);
    endtask

    task automatic endSession(input bit reassert);
        int waited;
        waited = 0;
        byte_valid = 1'b0;
        flash = 1'b0;
        while (!load_done && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("doneSeen", {31'd0, load_done}, 32'd1);
        if (reassert) flash = 1'b1;
        @(negedge clk);
        checkOutput("holdFall", {31'd0, cpu_hold}, 32'd0);
        checkOutput("idleReady", {31'd0, byte_ready}, 32'd0);
        if (reassert) begin
            @(negedge clk);
            checkOutput("restartHold", {31'd0, cpu_hold}, 32'd1);
            checkOutput("restartErrClear", {31'd0, err}, 32'd0);
        end
    endtask

    // Scoreboard monitor: every write strobe or done pulse must match the oldest expected entry.
    always @(negedge clk) begin
        expItem_t item;
        if (imem_we || load_done) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedEvent", {30'd0, imem_we, load_done}, 32'd0);
            end else begin
                item = expQ.pop_front();
                if (item.isDone) begin
                    checkOutput("doneStrobe", {30'd0, imem_we, load_done}, 32'd1);
                    checkOutput("doneCount", {19'd0, word_count}, {19'd0, item.count});
                    checkOutput("doneHold", {31'd0, cpu_hold}, 32'd1);
                end else begin
                    checkOutput("writeStrobe", {30'd0, imem_we, load_done}, 32'd2);
                    checkOutput("writeAddr", {20'd0, imem_waddr}, {20'd0, item.waddr});
                    checkOutput("writeData", imem_wdata, item.wdata);
                    checkOutput("writeCount", {19'd0, word_count}, {19'd0, item.count});
                    checkOutput("writeReadyLow", {31'd0, byte_ready}, 32'd0);
                end
            end
        end else begin
            checkOutput("quietAddr", {20'd0, imem_waddr}, 32'd0);
            checkOutput("quietData", imem_wdata, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("resetHold", {31'd0, cpu_hold}, 32'd0);
        checkOutput("resetReady", {31'd0, byte_ready}, 32'd0);
        checkOutput("resetCount", {19'd0, word_count}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Full word, then partial word flushed at session end; flash re-raised during DONE
        startSession();
        expectWrite(12'd0, 32'h0000_0013, 13'd1);
        applyStimulus(14'd0, 8'h13, 1'b0, w);
        applyStimulus(14'd1, 8'h00, 1'b0, w);
        applyStimulus(14'd2, 8'h00, 1'b0, w);
        applyStimulus(14'd3, 8'h00, 1'b0, w);
        expectWrite(12'd1, 32'h0000_BBAA, 13'd2);
        expectDone(13'd2);
        applyStimulus(14'd4, 8'hAA, 1'b0, w);
        applyStimulus(14'd5, 8'hBB, 1'b0, w);
        checkOutput("cleanErr", {31'd0, err}, 32'd0);
        endSession(1'b1);

        // Word address jump with a partial word pending
        applyStimulus(14'd8, 8'h11, 1'b0, w);
        applyStimulus(14'd16, 8'h22, 1'b0, w);
        checkOutput("jumpErr", {31'd0, err}, 32'd1);
        expectWrite(12'd4, 32'h0000_0022, 13'd1);
        expectDone(13'd1);
        endSession(1'b0);
        checkOutput("errSticky", {31'd0, err}, 32'd1);
        checkOutput("countHold", {19'd0, word_count}, 32'd1);

        // Out-of-range byte is dropped
        startSession();
        applyStimulus(14'h3FFF, 8'h55, 1'b0, w);
        checkOutput("rangeErr", {31'd0, err}, 32'd1);
        expectDone(13'd0);
        endSession(1'b0);

        // Reset in the middle of a word
        startSession();
        applyStimulus(14'h20, 8'hC1, 1'b0, w);
        applyStimulus(14'h21, 8'hC2, 1'b0, w);
        reset = 1'b0;
        #1;
        checkOutput("abortOutputs", {imem_we, load_done, cpu_hold, byte_ready, err, 27'd0}, 32'd0);
        checkOutput("abortCount", {19'd0, word_count}, 32'd0);
        checkOutput("abortBus", {20'd0, imem_waddr} | imem_wdata, 32'd0);
        flash = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("afterResetHold", {31'd0, cpu_hold}, 32'd0);
        checkOutput("afterResetReady", {31'd0, byte_ready}, 32'd0);

        // Continuous byte_valid across two words
        startSession();
        expectWrite(12'd0, 32'h0403_0201, 13'd1);
        expectWrite(12'd1, 32'h0807_0605, 13'd2);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(14'(i), 8'(i + 1), 1'b1, w);
            checkOutput("streamWait", w, (i == 4) ? 32'd1 : 32'd0);
        end
        expectDone(13'd2);
        endSession(1'b0);
        checkOutput("streamCount", {19'd0, word_count}, 32'd2);

        // Lane overwrite with an unwritten lane
        startSession();
        expectWrite(12'h10, 32'h4400_2299, 13'd1);
        applyStimulus(14'h40, 8'h11, 1'b0, w);
        applyStimulus(14'h40, 8'h99, 1'b0, w);
        applyStimulus(14'h41, 8'h22, 1'b0, w);
        applyStimulus(14'h43, 8'h44, 1'b0, w);
        checkOutput("overwriteErr", {31'd0, err}, 32'd0);
        expectDone(13'd1);
        endSession(1'b0);

        repeat (2) @(negedge clk);
        checkOutput("queueDrained", expQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
